// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Main control FSM for the multicycle ARM-subset datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               iClk,
    input  logic               iReset,
    input  logic [1:0]         iOp,
    input  logic [5:0]         iFunct,
    input  logic               iMemReady,
    output logic               oIRWrite,
    output logic               oNextPC,
    output logic               oAdrSrc,
    output logic               oALUSrcA,
    output logic [1:0]         oALUSrcB,
    output logic [1:0]         oResultSrc,
    output logic               oALUOp,
    output logic               oRegW,
    output logic               oMemW,
    output logic               oBranch,
    output logic               oInstrDone,
    output logic [STATE_W-1:0] oState
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_MEMADR = STATE_W'(2),
        S_MEMRD  = STATE_W'(3),
        S_MEMWB  = STATE_W'(4),
        S_MEMWR  = STATE_W'(5),
        S_EXECR  = STATE_W'(6),
        S_EXECI  = STATE_W'(7),
        S_ALUWB  = STATE_W'(8),
        S_BRANCH = STATE_W'(9)
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_irwrite;
    logic       w_nextpc;
    logic       w_adrsrc;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_resultsrc;
    logic       w_aluop;
    logic       w_regw;
    logic       w_memw;
    logic       w_branch;
    logic       w_done;

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = S_FETCH;
        w_irwrite   = 1'b0;
        w_nextpc    = 1'b0;
        w_adrsrc    = 1'b0;
        w_alusrca   = 1'b0;
        w_alusrcb   = 2'b00;
        w_resultsrc = 2'b00;
        w_aluop     = 1'b0;
        w_regw      = 1'b0;
        w_memw      = 1'b0;
        w_branch    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alusrca   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_irwrite   = iMemReady;
                w_nextpc    = iMemReady;
                w_next      = iMemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alusrca   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                case (iOp)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = iFunct[5] ? S_EXECI : S_EXECR;
                    2'b10:   w_next = S_BRANCH;
                    default: begin
                        // Undefined op retires as a NOP straight from decode
                        w_next = S_FETCH;
                        w_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrcb = 2'b01;
                w_next    = iFunct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_adrsrc = 1'b1;
                w_next   = iMemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regw      = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWR: begin
                w_adrsrc = 1'b1;
                w_memw   = 1'b1;
                w_done   = iMemReady;
                w_next   = iMemReady ? S_FETCH : S_MEMWR;
            end
            S_EXECR: begin
                w_aluop = 1'b1;
                w_next  = S_ALUWB;
            end
            S_EXECI: begin
                w_alusrcb = 2'b01;
                w_aluop   = 1'b1;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regw = 1'b1;
                w_done = 1'b1;
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                w_alusrcb   = 2'b01;
                w_resultsrc = 2'b10;
                w_branch    = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // FETCH decodes non-zero selects, so outputs are masked while reset is held
    assign oIRWrite   = w_irwrite & iReset;
    assign oNextPC    = w_nextpc  & iReset;
    assign oAdrSrc    = w_adrsrc  & iReset;
    assign oALUSrcA   = w_alusrca & iReset;
    assign oALUSrcB   = iReset ? w_alusrcb   : 2'b00;
    assign oResultSrc = iReset ? w_resultsrc : 2'b00;
    assign oALUOp     = w_aluop   & iReset;
    assign oRegW      = w_regw    & iReset;
    assign oMemW      = w_memw    & iReset;
    assign oBranch    = w_branch  & iReset;
    assign oInstrDone = w_done    & iReset;
    assign oState     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Scoreboard bench for multicycle_ctrl with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic       iClk;
    logic       iReset;
    logic [1:0] iOp;
    logic [5:0] iFunct;
    logic       iMemReady;
    logic       oIRWrite;
    logic       oNextPC;
    logic       oAdrSrc;
    logic       oALUSrcA;
    logic [1:0] oALUSrcB;
    logic [1:0] oResultSrc;
    logic       oALUOp;
    logic       oRegW;
    logic       oMemW;
    logic       oBranch;
    logic       oInstrDone;
    logic [3:0] oState;

    // Output vector: {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch,Done}
    localparam logic [12:0] c_ZERO   = 13'b0_0_0_0_00_00_0_0_0_0_0;
    localparam logic [12:0] c_F_RDY  = 13'b1_1_0_1_10_10_0_0_0_0_0;
    localparam logic [12:0] c_F_NR   = 13'b0_0_0_1_10_10_0_0_0_0_0;
    localparam logic [12:0] c_DEC    = 13'b0_0_0_1_10_10_0_0_0_0_0;
    localparam logic [12:0] c_DEC_D  = 13'b0_0_0_1_10_10_0_0_0_0_1;
    localparam logic [12:0] c_MADR   = 13'b0_0_0_0_01_00_0_0_0_0_0;
    localparam logic [12:0] c_MRD    = 13'b0_0_1_0_00_00_0_0_0_0_0;
    localparam logic [12:0] c_MWB    = 13'b0_0_0_0_00_01_0_1_0_0_1;
    localparam logic [12:0] c_MWR_W  = 13'b0_0_1_0_00_00_0_0_1_0_0;
    localparam logic [12:0] c_MWR_D  = 13'b0_0_1_0_00_00_0_0_1_0_1;
    localparam logic [12:0] c_EXR    = 13'b0_0_0_0_00_00_1_0_0_0_0;
    localparam logic [12:0] c_EXI    = 13'b0_0_0_0_01_00_1_0_0_0_0;
    localparam logic [12:0] c_ALUWB  = 13'b0_0_0_0_00_00_0_1_0_0_1;
    localparam logic [12:0] c_BR     = 13'b0_0_0_0_01_10_0_0_0_1_1;

    typedef struct packed {
        logic [3:0]  st;
        logic [12:0] outs;
        int          step;
    } exp_t;

    exp_t        q_exp[$];
    int          checks;
    int          errors;
    int          step_no;
    logic        stim_done;
    logic [12:0] w_act;

    assign w_act = {oIRWrite, oNextPC, oAdrSrc, oALUSrcA, oALUSrcB, oResultSrc,
                    oALUOp, oRegW, oMemW, oBranch, oInstrDone};

    multicycle_ctrl #(.STATE_W(4)) dut (
        .iClk       (iClk),
        .iReset     (iReset),
        .iOp        (iOp),
        .iFunct     (iFunct),
        .iMemReady  (iMemReady),
        .oIRWrite   (oIRWrite),
        .oNextPC    (oNextPC),
        .oAdrSrc    (oAdrSrc),
        .oALUSrcA   (oALUSrcA),
        .oALUSrcB   (oALUSrcB),
        .oResultSrc (oResultSrc),
        .oALUOp     (oALUOp),
        .oRegW      (oRegW),
        .oMemW      (oMemW),
        .oBranch    (oBranch),
        .oInstrDone (oInstrDone),
        .oState     (oState)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Monitor: every cycle the DUT presents a state/output vector mid-cycle
    always @(negedge iClk) begin
        if (q_exp.size() > 0) begin
            exp_t e;
            e = q_exp.pop_front();
            checks = checks + 1;
            if (oState !== e.st) begin
                errors = errors + 1;
                $display("FAIL state step %0d: got %0d expected %0d", e.step, oState, e.st);
            end
            checks = checks + 1;
            if (w_act !== e.outs) begin
                errors = errors + 1;
                $display("FAIL outputs step %0d (state %0d): got %b expected %b",
                         e.step, e.st, w_act, e.outs);
            end
        end
    end

    task automatic step(input logic rst_n, input logic rdy, input logic [1:0] op,
                        input logic [5:0] funct, input logic [3:0] st,
                        input logic [12:0] outs);
        exp_t e;
        @(posedge iClk);
        #1;
        iReset    = rst_n;
        iMemReady = rdy;
        iOp       = op;
        iFunct    = funct;
        e.st   = st;
        e.outs = outs;
        e.step = step_no;
        q_exp.push_back(e);
        step_no = step_no + 1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        step_no   = 0;
        stim_done = 1'b0;
        iReset    = 1'b0;
        iMemReady = 1'b1;
        iOp       = 2'b00;
        iFunct    = 6'b000000;

        // Reset state
        step(1'b0, 1'b1, 2'b00, 6'b000000, 4'd0, c_ZERO);
        step(1'b0, 1'b1, 2'b00, 6'b000000, 4'd0, c_ZERO);
        // DP register, reset asserted mid-EXECR
        step(1'b1, 1'b1, 2'b00, 6'b000000, 4'd0, c_F_RDY);
        step(1'b1, 1'b1, 2'b00, 6'b000000, 4'd1, c_DEC);
        step(1'b1, 1'b1, 2'b00, 6'b000000, 4'd6, c_EXR);
        step(1'b0, 1'b1, 2'b00, 6'b000000, 4'd0, c_ZERO);
        step(1'b0, 1'b1, 2'b00, 6'b000000, 4'd0, c_ZERO);
        // Release, then DP immediate: 0,1,7,8
        step(1'b1, 1'b1, 2'b00, 6'b100100, 4'd0, c_F_RDY);
        step(1'b1, 1'b1, 2'b00, 6'b100100, 4'd1, c_DEC);
        step(1'b1, 1'b1, 2'b00, 6'b100100, 4'd7, c_EXI);
        step(1'b1, 1'b1, 2'b00, 6'b100100, 4'd8, c_ALUWB);
        // LDR with two wait states in MEMRD
        step(1'b1, 1'b1, 2'b01, 6'b000001, 4'd0, c_F_RDY);
        step(1'b1, 1'b1, 2'b01, 6'b000001, 4'd1, c_DEC);
        step(1'b1, 1'b1, 2'b01, 6'b000001, 4'd2, c_MADR);
        step(1'b1, 1'b0, 2'b01, 6'b000001, 4'd3, c_MRD);
        step(1'b1, 1'b0, 2'b01, 6'b000001, 4'd3, c_MRD);
        step(1'b1, 1'b1, 2'b01, 6'b000001, 4'd3, c_MRD);
        step(1'b1, 1'b1, 2'b01, 6'b000001, 4'd4, c_MWB);
        // STR with one wait state
        step(1'b1, 1'b1, 2'b01, 6'b000000, 4'd0, c_F_RDY);
        step(1'b1, 1'b1, 2'b01, 6'b000000, 4'd1, c_DEC);
        step(1'b1, 1'b1, 2'b01, 6'b000000, 4'd2, c_MADR);
        step(1'b1, 1'b0, 2'b01, 6'b000000, 4'd5, c_MWR_W);
        step(1'b1, 1'b1, 2'b01, 6'b000000, 4'd5, c_MWR_D);
        // Fetch stall for three cycles, then branch
        step(1'b1, 1'b0, 2'b10, 6'b000000, 4'd0, c_F_NR);
        step(1'b1, 1'b0, 2'b10, 6'b000000, 4'd0, c_F_NR);
        step(1'b1, 1'b0, 2'b10, 6'b000000, 4'd0, c_F_NR);
        step(1'b1, 1'b1, 2'b10, 6'b000000, 4'd0, c_F_RDY);
        step(1'b1, 1'b1, 2'b10, 6'b000000, 4'd1, c_DEC);
        step(1'b1, 1'b1, 2'b10, 6'b000000, 4'd9, c_BR);
        // Undefined op retires from DECODE
        step(1'b1, 1'b1, 2'b11, 6'b111111, 4'd0, c_F_RDY);
        step(1'b1, 1'b1, 2'b11, 6'b111111, 4'd1, c_DEC_D);
        step(1'b1, 1'b1, 2'b00, 6'b000000, 4'd0, c_F_RDY);

        @(negedge iClk);
        #1;
        stim_done = 1'b1;
    end

    initial begin : g_finish
        int cyc;
        cyc = 0;
        while (!(stim_done && q_exp.size() == 0) && cyc < 1000) begin
            @(posedge iClk);
            cyc = cyc + 1;
        end
        if (cyc >= 1000) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL timeout: %0d expectations pending, required 0", q_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
